// File: rtl/shift_xfer_if.sv
// Parallel/serial transfer bus between a shift_xfer engine and its user.
interface shift_xfer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] D;
    logic             SI;
    logic             SO;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             done;

    // User side: requests transfers and supplies the serial input.
    modport master (
        output start, D, SI,
        input  SO, Q, busy, done
    );

    // Engine side.
    modport slave (
        input  start, D, SI,
        output SO, Q, busy, done
    );
endinterface

// File: rtl/shift_xfer.sv
// Serial shifter: loads a parallel word, shifts it out on SO while shifting
// SI in, then presents the received word on Q with a one-cycle done pulse.
module shift_xfer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTb,
    shift_xfer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] q_reg, q_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg_shifted;

    // One-bit shift toward the output end, SI entering at the vacated end.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_shifted = {sreg[WIDTH-2:0], bus.SI};
        end else begin
            sreg_shifted = {bus.SI, sreg[WIDTH-1:1]};
        end
    end

    // State register bank; reset discards any partial transfer.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= S_IDLE;
            sreg  <= '0;
            cnt   <= '0;
            q_reg <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            q_reg <= q_nxt;
        end
    end

    // Transaction sequencing; cnt saturates at WIDTH-1 on the last shift.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        q_nxt     = q_reg;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    sreg_nxt  = bus.D;
                    cnt_nxt   = '0;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sreg_nxt = sreg_shifted;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                q_nxt     = sreg;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; SO is quiet outside SHIFT.
    assign bus.SO   = (state == S_SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 1'b0;
    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.Q    = q_reg;
endmodule

// File: tb/tb_shift_xfer.sv
// Directed self-checking bench for shift_xfer across several widths/orders.
module tb_shift_xfer;
    logic CLK;
    logic RSTb;

    int n_checks;
    int n_fail;

    shift_xfer_if #(.WIDTH(8))  bus_a ();
    shift_xfer_if #(.WIDTH(8))  bus_b ();
    shift_xfer_if #(.WIDTH(16)) bus_c ();
    shift_xfer_if #(.WIDTH(2))  bus_d ();

    shift_xfer #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_a (.CLK(CLK), .RSTb(RSTb), .bus(bus_a.slave));
    shift_xfer #(.WIDTH(8),  .MSB_FIRST(1'b0)) u_b (.CLK(CLK), .RSTb(RSTb), .bus(bus_b.slave));
    shift_xfer #(.WIDTH(16), .MSB_FIRST(1'b0)) u_c (.CLK(CLK), .RSTb(RSTb), .bus(bus_c.slave));
    shift_xfer #(.WIDTH(2),  .MSB_FIRST(1'b1)) u_d (.CLK(CLK), .RSTb(RSTb), .bus(bus_d.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic [63:0] d, input logic si);
        case (sel)
            0: begin bus_a.start = st; bus_a.D = d[7:0];  bus_a.SI = si; end
            1: begin bus_b.start = st; bus_b.D = d[7:0];  bus_b.SI = si; end
            2: begin bus_c.start = st; bus_c.D = d[15:0]; bus_c.SI = si; end
            default: begin bus_d.start = st; bus_d.D = d[1:0]; bus_d.SI = si; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic so, output logic busy,
                           output logic done, output logic [63:0] q);
        case (sel)
            0: begin so = bus_a.SO; busy = bus_a.busy; done = bus_a.done; q = 64'(bus_a.Q); end
            1: begin so = bus_b.SO; busy = bus_b.busy; done = bus_b.done; q = 64'(bus_b.Q); end
            2: begin so = bus_c.SO; busy = bus_c.busy; done = bus_c.done; q = 64'(bus_c.Q); end
            default: begin so = bus_d.SO; busy = bus_d.busy; done = bus_d.done; q = 64'(bus_d.Q); end
        endcase
    endtask

    // One transaction: bit i of si_seq/so_exp is the i-th bit in shift order.
    task automatic xfer(input int sel, input int w, input logic [63:0] d,
                        input logic [63:0] si_seq, input logic [63:0] so_exp,
                        input logic [63:0] q_exp, input bit loopback, input string tag);
        logic so, busy, done;
        logic [63:0] q;
        logic [63:0] so_got;
        so_got = '0;
        @(negedge CLK);
        set_in(sel, 1'b1, d, 1'b0);
        @(posedge CLK);
        #1;
        set_in(sel, 1'b0, ~d, 1'b0);
        for (int i = 0; i < w; i++) begin
            @(negedge CLK);
            get_out(sel, so, busy, done, q);
            so_got[i] = so;
            if (i == 0) check_eq({tag, "_busy_rise"}, 64'(busy), 64'd1);
            if (i == w - 1) check_eq({tag, "_no_early_done"}, 64'(done), 64'd0);
            // a start pulse mid-shift must be ignored
            set_in(sel, (i == 1), ~d, loopback ? so : si_seq[i]);
        end
        check_eq({tag, "_so_seq"}, so_got, so_exp);
        @(negedge CLK);
        get_out(sel, so, busy, done, q);
        set_in(sel, 1'b0, ~d, 1'b0);
        check_eq({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd3);
        check_eq({tag, "_so_idle_in_done"}, 64'(so), 64'd0);
        @(negedge CLK);
        get_out(sel, so, busy, done, q);
        check_eq({tag, "_end_flags"}, {62'd0, done, busy}, 64'd0);
        check_eq({tag, "_q"}, q, q_exp);
    endtask

    initial begin
        logic so, busy, done;
        logic [63:0] q;
        logic prev_busy, collecting;
        logic [7:0] last_d, exp_word, word;
        int bitpos, n_acc, n_done, last_acc;

        n_checks = 0;
        n_fail   = 0;
        RSTb = 1'b0;
        for (int s = 0; s < 4; s++) set_in(s, 1'b0, 64'd0, 1'b0);
        repeat (2) @(negedge CLK);

        // Reset values
        get_out(0, so, busy, done, q);
        check_eq("rst_a", {so, busy, done, q[60:0]}, 64'd0);
        get_out(3, so, busy, done, q);
        check_eq("rst_d", {so, busy, done, q[60:0]}, 64'd0);
        RSTb = 1'b1;

        // MSB-first W8: D=A5, SI=0
        xfer(0, 8, 64'hA5, 64'h00, 64'hA5, 64'h00, 1'b0, "a5");
        // MSB-first W8: SI 1,1,0,0,0,0,0,1 -> C1; D=0F shifts out 0,0,0,0,1,1,1,1
        xfer(0, 8, 64'h0F, 64'h83, 64'hF0, 64'hC1, 1'b0, "msb_si");

        // Reset mid-shift of FF aborts and clears Q immediately
        @(negedge CLK);
        set_in(0, 1'b1, 64'hFF, 1'b0);
        @(posedge CLK);
        #1;
        set_in(0, 1'b0, 64'h00, 1'b0);
        repeat (3) @(negedge CLK);
        get_out(0, so, busy, done, q);
        check_eq("pre_rst_shift", {62'd0, so, busy}, 64'd3);
        RSTb = 1'b0;
        #1;
        get_out(0, so, busy, done, q);
        check_eq("mid_rst_flags", {61'd0, so, busy, done}, 64'd0);
        check_eq("mid_rst_q", q, 64'd0);
        @(negedge CLK);
        RSTb = 1'b1;
        xfer(0, 8, 64'h01, 64'h00, 64'h80, 64'h00, 1'b0, "post_rst");

        // LSB-first W8: SI 1,0,0,0,0,0,1,1 -> C1
        xfer(1, 8, 64'h96, 64'hC1, 64'h96, 64'hC1, 1'b0, "lsb_si");
        // Loopback
        xfer(0, 8, 64'h3C, 64'h00, 64'h3C, 64'h3C, 1'b1, "loop3c");
        xfer(2, 16, 64'h8001, 64'h00, 64'h8001, 64'h8001, 1'b1, "w16");
        // Minimum width: D=10, SI 0,1 -> SO 1,0, Q=01
        xfer(3, 2, 64'h2, 64'h2, 64'h1, 64'h1, 1'b0, "w2");

        // start held high with D changing every cycle
        prev_busy  = 1'b0;
        collecting = 1'b0;
        last_d     = 8'h00;
        exp_word   = 8'h00;
        word       = 8'h00;
        bitpos     = 0;
        n_acc      = 0;
        n_done     = 0;
        last_acc   = 0;
        for (int cyc = 0; cyc < 32; cyc++) begin
            @(negedge CLK);
            get_out(0, so, busy, done, q);
            if (busy && !prev_busy) begin
                if (n_acc > 0) check_eq("accept_spacing", 64'(cyc - last_acc), 64'd10);
                n_acc++;
                last_acc   = cyc;
                exp_word   = last_d;
                collecting = 1'b1;
                bitpos     = 0;
            end
            if (collecting) begin
                word = {word[6:0], so};
                bitpos++;
                if (bitpos == 8) begin
                    check_eq("stream_word", 64'(word), 64'(exp_word));
                    collecting = 1'b0;
                end
            end
            if (done) n_done++;
            prev_busy = busy;
            last_d = 8'(cyc * 37 + 5);
            set_in(0, 1'b1, 64'(last_d), 1'b0);
        end
        check_eq("stream_accepts", 64'(n_acc), 64'd4);
        check_eq("stream_dones", 64'(n_done), 64'd3);
        set_in(0, 1'b0, 64'd0, 1'b0);
        repeat (12) @(negedge CLK);
        get_out(0, so, busy, done, q);
        check_eq("stream_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_xfer.md
# shift_xfer

Parametrised serial shifter: loads a WIDTH-bit parallel word, shifts it out one bit per clock on SO while shifting a new word in on SI, then presents the received word on Q with a one-cycle done pulse. It extends the single-bit D storage elements into a controlled, multi-bit register bank with a transaction state machine. It is the serial engine for SPI-style links and for register-chain tests.

## Interface
- WIDTH, 8: word width in bits; legal range 2 to 64.
- MSB_FIRST, 1: 1 = shift left, MSB out first, SI enters at bit 0. 0 = shift right, LSB out first, SI enters at bit WIDTH-1.

- CLK  in  1  clock; all state changes on the rising edge.
- RSTb  in  1  reset, asynchronous, active-low.
- start  in  1  transaction request; sampled only in IDLE.
- D  in  WIDTH  parallel word to transmit; captured on the accepting edge.
- SI  in  1  serial input; sampled on each shift edge.
- SO  out  1  serial output.
- Q  out  WIDTH  last received word; holds until the next DONE.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse in DONE.

## Operation
- State registers: state (IDLE, SHIFT, DONE), sreg[WIDTH-1:0], cnt of width $clog2(WIDTH+1), Q.
- IDLE:
  - start=1: sreg<=D, cnt<=0, go to SHIFT.
  - Otherwise hold.
- SHIFT, on each edge:
  - sreg shifts by one, inserting SI at the vacated end (MSB_FIRST: {sreg[WIDTH-2:0],SI}; else {SI,sreg[WIDTH-1:1]}).
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 (last shift), go to DONE.
- DONE: Q<=sreg on the exit edge, then go to IDLE. done=1 for this cycle only.
- SO is combinational:
  - In SHIFT: sreg[WIDTH-1] when MSB_FIRST, else sreg[0].
  - In IDLE and DONE: 0.
- busy = (state != IDLE), decoded from state.
- start in SHIFT or DONE is ignored, not queued. D and start changes during a transaction have no effect.
- Reset at any time, including mid-SHIFT, aborts the transaction. Partial data is discarded; Q is not updated.
- cnt never exceeds WIDTH-1 and never wraps.

## Timing
- Reset values: state=IDLE, sreg=0, cnt=0, Q=0, SO=0, busy=0, done=0.
- Start accepted at edge k:
  - busy rises after edge k.
  - Bit i of D is on SO during the cycle before edge k+1+i, for i=0..WIDTH-1 in shift order.
  - SI is sampled at edges k+1 through k+WIDTH.
  - done=1 between edges k+WIDTH and k+WIDTH+1.
  - Q is updated and busy falls after edge k+WIDTH+1.
- With start held high, transactions begin every WIDTH+2 cycles.
- Loopback (SO tied to SI) returns Q==D.

## Test plan
- Reset: assert RSTb=0 mid-SHIFT of D=8'hFF -> SO=0, busy=0, done=0, Q=0 immediately. After release, start with D=8'h01 -> normal transaction.
- MSB_FIRST=1, WIDTH=8, D=8'hA5, SI=0 -> SO sequence 1,0,1,0,0,1,0,1. done pulses exactly 8 cycles after the accept edge. Q=8'h00.
- MSB_FIRST=1, WIDTH=8, SI sequence 1,1,0,0,0,0,0,1 -> Q=8'hC1. MSB_FIRST=0 with SI sequence 1,0,0,0,0,0,1,1 -> Q=8'hC1.
- Loopback SO->SI, D=8'h3C -> Q=8'h3C. WIDTH=16, MSB_FIRST=0, D=16'h8001 -> SO sequence 1, then 0 fourteen times, then 1; Q=16'h8001.
- start held high; D changed every cycle -> accepts spaced exactly 10 cycles apart (WIDTH=8). Each transmitted word equals D at its accept edge. One done per transaction.
- WIDTH=2 minimum: D=2'b10, SI sequence 0,1 -> SO sequence 1,0. done 2 cycles after accept; Q=2'b01.
